// File: rtl/serial_out_sequencer.sv
// serial_out_sequencer: queues words in a small FIFO and feeds them one at a
// time to a serializer as a single frame (start pulse, wait for done, gap).
// Optional feature: define SEQ_TIMEOUT_EN to enable the WAIT watchdog that
// aborts the frame after TIMEOUT_CYC cycles without a serializer done tick.
module serial_out_sequencer #(
  parameter int DATA_BIT    = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_wr_valid,
  input  logic [DATA_BIT-1:0]           i_wr_data,
  input  logic                          i_wr_freq,
  output logic                          o_wr_ready,
  input  logic                          i_go,
  input  logic                          i_abort,
  output logic                          o_ser_start,
  output logic                          o_ser_stop,
  output logic [DATA_BIT-1:0]           o_ser_data,
  output logic                          o_ser_sel_freq,
  input  logic                          i_ser_done,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  // Reject configurations the pointer arithmetic cannot support
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      GAP_CYC < 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("serial_out_sequencer: invalid parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t              state;
  logic [DATA_BIT:0]   mem [FIFO_DEPTH];
  logic [DATA_BIT:0]   head;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [GW-1:0]       gap_cnt;
  logic                push;
  logic                pop;
  logic                flush;
  logic                abort_hit;
  logic                timeout_hit;
  logic                seg_end;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0]       wait_cnt;
`endif

  assign o_wr_ready = (o_level != LW'(FIFO_DEPTH));
  assign o_busy     = (state != ST_IDLE);
  assign head       = mem[rd_ptr];

  // Control decode: abort/watchdog flush wins over everything else; a word
  // segment ends at the last GAP cycle, or directly on done when GAP is bypassed
  always_comb begin
    abort_hit   = i_abort && (state == ST_START || state == ST_WAIT || state == ST_GAP);
    timeout_hit = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    timeout_hit = !abort_hit && (state == ST_WAIT) && !i_ser_done &&
                  (wait_cnt == TW'(TIMEOUT_CYC - 1));
`endif
    flush   = abort_hit || timeout_hit;
    seg_end = !flush && (((state == ST_GAP) && (gap_cnt == GAP_LAST)) ||
                         ((GAP_CYC == 0) && (state == ST_WAIT) && i_ser_done));
    pop     = (o_level != '0) && (((state == ST_IDLE) && i_go) || seg_end);
    push    = i_wr_valid && o_wr_ready && !flush;
  end

  // FIFO storage (no reset needed: occupancy gates every read)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_wr_freq, i_wr_data};
  end

  // FIFO pointers and occupancy; a flush discards everything queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_level <= o_level + 1'b1;
        2'b01:   o_level <= o_level - 1'b1;
        default: o_level <= o_level;
      endcase
    end
  end

  // Frame sequencer with registered serializer-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      o_ser_data     <= '0;
      o_ser_sel_freq <= 1'b0;
      o_ser_start    <= 1'b0;
      o_ser_stop     <= 1'b0;
      o_frame_done   <= 1'b0;
      gap_cnt        <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt       <= '0;
      o_timeout      <= 1'b0;
`endif
    end else begin
      o_ser_start  <= 1'b0;
      o_ser_stop   <= 1'b0;
      o_frame_done <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      o_timeout    <= 1'b0;
`endif
      if (flush) begin
        state      <= ST_IDLE;
        o_ser_stop <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
        o_timeout  <= timeout_hit;
`endif
      end else if (pop) begin
        state          <= ST_START;
        o_ser_data     <= head[DATA_BIT-1:0];
        o_ser_sel_freq <= head[DATA_BIT];
        o_ser_start    <= 1'b1;
      end else if (seg_end) begin
        state        <= ST_DONE;
        o_frame_done <= 1'b1;
      end else begin
        case (state)
          ST_START: begin
            state <= ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
          ST_WAIT: begin
            if (i_ser_done) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
`ifdef SEQ_TIMEOUT_EN
            else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
`endif
          end
          ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
          ST_DONE: state   <= ST_IDLE;
          default: state   <= ST_IDLE;
        endcase
      end
    end
  end

`ifndef SEQ_TIMEOUT_EN
  assign o_timeout = 1'b0;
`endif

endmodule
